block_data_memory: RTL

//  - Memory-side responder for the cache's block bus (mem_read/mem_write/mem_address/mem_busywait).
//  - Holds 64 x 32-bit blocks. Each access runs for a fixed multi-cycle latency and is handshaken

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_array.sv | 28 ++
 rtl/block_data_memory.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing for the block-bus data memory.
// Used by dmem_array and block_data_memory.
package dmem_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 6;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int LATENCY_W = 4;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Request captured at accept; the bus may change freely afterwards.
    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dmem_req_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Block storage: synchronous write, registered read.
// Contents are never reset.
module dmem_array
    import dmem_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/block_data_memory.sv
// Multi-cycle block memory responder with busywait handshake.
// Optional access statistics under `DMEM_ACCESS_COUNT_EN.
module block_data_memory
    import dmem_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_writedata,
    output logic [DATA_W-1:0] mem_readdata,
    output logic              mem_busywait
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [CNT_W-1:0]  read_count,
    output logic [CNT_W-1:0]  write_count
`endif
);

    localparam logic [LATENCY_W-1:0] CNT_INIT =
        LATENCY_W'(LATENCY - 1);

    dmem_state_t          r_state;
    logic [LATENCY_W-1:0] r_cnt;
    dmem_req_t            r_req;
    logic                 r_rd_valid;

    logic              w_req;
    logic              w_last;
    logic              w_we;
    logic              w_re;
    logic              w_busy;
    logic [DATA_W-1:0] w_rdata;

    assign w_req  = mem_read | mem_write;
    assign w_last = (r_state == BUSY) && (r_cnt == '0);
    assign w_we   = w_last & r_req.is_write;
    assign w_re   = w_last & ~r_req.is_write;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_req      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_req.is_write <= mem_write;
                        r_req.addr     <= mem_address;
                        r_req.data     <= mem_writedata;
                        r_cnt          <= CNT_INIT;
                        r_state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        if (!r_req.is_write) begin
                            r_rd_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_busy = 1'b0;
        if (reset) begin
            unique case (r_state)
                IDLE:    w_busy = w_req;
                BUSY:    w_busy = 1'b1;
                DONE:    w_busy = 1'b0;
                default: w_busy = 1'b0;
            endcase
        end
    end

    assign mem_busywait = w_busy;

    dmem_array u_array (
        .clock (clock),
        .we    (w_we),
        .re    (w_re),
        .addr  (r_req.addr),
        .wdata (r_req.data),
        .rdata (w_rdata)
    );

    // The array's read register has no reset; mask it until a read lands.
    assign mem_readdata = r_rd_valid ? w_rdata : '0;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [CNT_W-1:0] r_read_count;
    logic [CNT_W-1:0] r_write_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_read_count  <= '0;
            r_write_count <= '0;
        end else if (r_state == IDLE && w_req) begin
            if (mem_write) begin
                r_write_count <= sat_inc(r_write_count);
            end else begin
                r_read_count <= sat_inc(r_read_count);
            end
        end
    end

    assign read_count  = r_read_count;
    assign write_count = r_write_count;
`endif

endmodule
